// File: rtl/lz_denorm.sv
// lz_denorm: multi-cycle denormalizer, the inverse of a leading-zero counter.
// A word is accepted in IDLE, shifted right by up to STEP bits per SHIFT cycle
// until the requested leading-zero count is reached, then presented in DONE
// until the consumer takes it.
module lz_denorm #(
  parameter int WIDTH = 32,
  parameter int STEP  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [5:0]       in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ok
);

  // Remainder width: large enough to hold any effective count 0..WIDTH.
  localparam int              RW      = $clog2(WIDTH + 1);
  localparam logic [RW-1:0]   FULL_R  = RW'(WIDTH);
  localparam logic [RW-1:0]   STEP_R  = RW'(STEP);
  localparam logic [31:0]     WIDTH_U = 32'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [RW-1:0]     r_rem;
  logic [RW-1:0]     w_rem_next;
  logic [WIDTH-1:0]  r_data;
  logic [WIDTH-1:0]  w_data_next;
  logic              r_ok;
  logic              w_ok_next;

  logic [31:0]       w_count_wide;
  logic [RW-1:0]     w_eff;
  logic [RW-1:0]     w_s;
  logic [WIDTH-1:0]  w_shifted;

  // Effective count saturates at WIDTH; the compare is done at 32 bits so it
  // is valid for any WIDTH, including ones narrower than the 6-bit count.
  always_comb begin
    w_count_wide = 32'(in_count);
    if (w_count_wide >= WIDTH_U) begin
      w_eff = FULL_R;
    end else begin
      w_eff = w_count_wide[RW-1:0];
    end
  end

  // Per-cycle shift amount is the smaller of the remainder and STEP.
  always_comb begin
    if (r_rem > STEP_R) begin
      w_s = STEP_R;
    end else begin
      w_s = r_rem;
    end
    w_shifted = r_data >> w_s;
  end

  // Next-state and datapath update; everything holds unless a state acts.
  always_comb begin
    w_state_next = r_state;
    w_rem_next   = r_rem;
    w_data_next  = r_data;
    w_ok_next    = r_ok;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_data_next = in_data;
          w_rem_next  = w_eff;
          // A zero-filled result still has the requested CLZ, so a full-width
          // count is always correct even when the input was unnormalized.
          w_ok_next   = in_data[WIDTH-1] | (w_eff == FULL_R);
          if (w_eff == '0) begin
            w_state_next = DONE;
          end else begin
            w_state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        w_data_next = w_shifted;
        w_rem_next  = r_rem - w_s;
        if (r_rem == w_s) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_data  <= '0;
      r_ok    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_rem   <= w_rem_next;
      r_data  <= w_data_next;
      r_ok    <= w_ok_next;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_data  = r_data;
  assign out_ok    = r_ok;

endmodule

// File: tb/tb_lz_denorm.sv
// Testbench for lz_denorm: directed table, count sweep, reset abort and
// randomized transactions checked against an arithmetic reference model.
module tb_lz_denorm;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [5:0]  in_count;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ok;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lz_denorm #(.WIDTH(32), .STEP(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_count  (in_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ok    (out_ok)
  );

  typedef struct {
    logic [31:0] data;
    logic [5:0]  count;
    int          stall;
    logic [31:0] exp_data;
    logic        exp_ok;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: CLZ inverse from plain arithmetic.
  task automatic model(input logic [31:0] d, input logic [5:0] c,
                       output logic [31:0] ed, output logic eok, output int elat);
    int eff;
    eff  = (int'(c) > 32) ? 32 : int'(c);
    ed   = (eff == 32) ? 32'd0 : (d >> eff);
    eok  = d[31] || (eff == 32);
    elat = 1 + (eff + 7) / 8;
  endtask

  // One full transaction; called #1 after a rising edge with the DUT idle.
  task automatic run_txn(input string tag, input logic [31:0] d, input logic [5:0] c,
                         input int stall, input logic [31:0] ed, input logic eok,
                         input int elat);
    int          lat;
    logic [31:0] held_data;
    logic        held_ok;
    check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = d;
    in_count  = c;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    lat = 1;
    // Garbage requests while busy must be ignored.
    while (!out_valid && lat < 40) begin
      check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      in_count = 6'($urandom_range(0, 63));
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " out_data"}, out_data, ed);
    check({tag, " out_ok"}, 32'(out_ok), 32'(eok));
    held_data = out_data;
    held_ok   = out_ok;
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      in_count = 6'($urandom_range(0, 63));
      @(posedge clk); #1;
      check({tag, " stall out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
      check({tag, " stall data"}, out_data, held_data);
      check({tag, " stall ok"}, 32'(out_ok), 32'(held_ok));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
    check({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
    $display("txn %s: data=0x%08h count=%0d stall=%0d -> out=0x%08h ok=%0d lat=%0d",
             tag, d, c, stall, held_data, held_ok, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs[4];
    logic [31:0] ed;
    logic        eok;
    int          elat;
    logic [31:0] rd;
    logic [5:0]  rc;

    vecs[0] = '{32'h8000_0000, 6'd0,  0, 32'h8000_0000, 1'b1, 1};
    vecs[1] = '{32'hF000_0000, 6'd13, 0, 32'h0007_8000, 1'b1, 3};
    vecs[2] = '{32'h8000_0001, 6'd40, 0, 32'h0000_0000, 1'b1, 5};
    vecs[3] = '{32'h00FF_0000, 6'd4,  6, 32'h000F_F000, 1'b0, 2};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_count = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset out_ok", 32'(out_ok), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    foreach (vecs[i]) begin
      run_txn($sformatf("vec%0d", i), vecs[i].data, vecs[i].count, vecs[i].stall,
              vecs[i].exp_data, vecs[i].exp_ok, vecs[i].exp_lat);
    end

    // Count sweep on a normalized word
    for (int c = 0; c <= 32; c++) begin
      ed   = (c == 32) ? 32'd0 : (32'd1 << (31 - c));
      elat = 1 + (c + 7) / 8;
      run_txn($sformatf("sweep%0d", c), 32'h8000_0000, 6'(c), 0, ed, 1'b1, elat);
    end

    // Reset in the second SHIFT cycle aborts the transaction
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_count = 6'd32; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort out_data", out_data, 32'd0);
    check("abort out_ok", 32'(out_ok), 32'd0);
    $display("txn abort: reset during SHIFT");
    run_txn("after_abort", 32'hF000_0000, 6'd13, 0, 32'h0007_8000, 1'b1, 3);

    // Randomized transactions against the model
    for (int i = 0; i < 40; i++) begin
      rd = $urandom;
      if ($urandom_range(0, 1) == 1) rd[31] = 1'b1;
      rc = 6'($urandom_range(0, 63));
      model(rd, rc, ed, eok, elat);
      run_txn($sformatf("rand%0d", i), rd, rc, $urandom_range(0, 3), ed, eok, elat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lz_denorm.md
LZ_DENORM -- requirements
Module: lz_denorm

Interface
REQ-001 Parameter: WIDTH, default 32; data width in bits.
REQ-002 Parameter: STEP, default 8; maximum right-shift applied per SHIFT cycle; must be a power of two no larger than WIDTH.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  request present.
REQ-006 Port: in_ready  output  1  block can accept a request.
REQ-007 Port: in_data  input  WIDTH  normalized word; MSB expected set.
REQ-008 Port: in_count  input  6  target leading-zero count, 0..63.
REQ-009 Port: out_valid  output  1  result present.
REQ-010 Port: out_ready  input  1  consumer accepts the result.
REQ-011 Port: out_data  output  WIDTH  in_data logically right-shifted by the effective count.
REQ-012 Port: out_ok  output  1  CLZ(out_data) equals the effective count.

Function
REQ-013 The block SHALL act as the inverse of the combinational 32-bit leading-zero counter: it denormalizes a word so that its CLZ equals the requested count.
REQ-014 The effective count SHALL be min(in_count, WIDTH); counts above WIDTH saturate and produce out_data = 0.
REQ-015 The state machine SHALL have three states: IDLE, SHIFT and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; a request is accepted on an edge where in_valid and in_ready are both 1.
REQ-017 On accept, the block SHALL register in_data and the effective count into a remainder register rem.
REQ-018 On accept with rem = 0, the next state SHALL be DONE; otherwise it SHALL be SHIFT.
REQ-019 In each SHIFT cycle, the data SHALL shift right by s = min(rem, STEP), zero-filling from the MSB side, and rem SHALL decrease by s.
REQ-020 SHIFT SHALL go to DONE in the same cycle that rem becomes 0.
REQ-021 Latency from the accept edge to out_valid = 1 SHALL be 1 + ceil(c/STEP) cycles, where c is the effective count; with defaults, c=0 gives 1, c=1..8 gives 2 and c=32 gives 5.
REQ-022 out_valid SHALL be 1 only in DONE; out_data and out_ok SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-023 DONE SHALL return to IDLE on an edge with out_ready = 1, so in_ready rises one cycle after the handshake; there is no same-cycle accept from DONE.
REQ-024 out_ok SHALL be 1 when the captured in_data MSB was 1 or c = WIDTH, and 0 otherwise.
REQ-025 in_valid, in_data and in_count SHALL be ignored outside IDLE; there is no internal queue and requests are never dropped silently.
REQ-026 Only one transaction SHALL be in flight at a time.

Reset
REQ-027 When rst = 1 at a rising edge, the block SHALL enter IDLE and clear rem, the data register and out_ok to 0.
REQ-028 Reset values SHALL be: in_ready = 1, out_valid = 0, out_data = 0, out_ok = 0.
REQ-029 Reset in SHIFT or DONE SHALL abort the transaction with no output handshake; the first cycle after reset SHALL behave exactly as IDLE.
REQ-030 rst SHALL take priority over every handshake in the same cycle.

Verification
REQ-031 Zero count: in_data=0x80000000, in_count=0, out_ready=1 -> out_valid 1 cycle after accept, out_data=0x80000000, out_ok=1.
REQ-032 Multi-step shift: in_data=0xF0000000, in_count=13 -> out_valid 3 cycles after accept (shifts 8 then 5), out_data=0x00078000, out_ok=1.
REQ-033 Saturation: in_data=0x80000001, in_count=40 -> effective count 32, out_valid 5 cycles after accept, out_data=0, out_ok=1.
REQ-034 Unnormalized input and backpressure: in_data=0x00FF0000, in_count=4, out_ready=0 for 6 cycles -> out_data=0x000FF000 held stable with out_ok=0, in_ready=0 throughout, in_valid pulses ignored; in_ready=1 the cycle after out_ready=1.
REQ-035 Reset mid-operation: accept with in_count=32, assert rst in the 2nd SHIFT cycle -> next cycle in_ready=1, out_valid=0, out_data=0; a new request then completes normally.
REQ-036 Exhaustive sweep: in_data=0x80000000 with counts 0..32 back-to-back -> out_data = 1 << (31-c) (0 when c=32), latency per REQ-021, out_ok=1 for every count.
